// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants and types for the SHA-256 datapath blocks.
//   WORD_W       : width of one message/schedule word
//   BLOCK_WORDS  : words in one 512-bit message block
//   ROUNDS_MAX   : schedule words produced per block for full SHA-256
//   word_t       : one 32-bit word, bit 0 is the MSB
//   idx_t        : schedule index 0..63, bit 0 is the MSB
//   state_e      : schedule expander state (LOAD / EMIT)
//   rotr()       : 32-bit rotate right, used by the small-sigma functions
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS_MAX  = 64;
  localparam int IDX_W       = 6;

  typedef logic [0:WORD_W-1] word_t;
  typedef logic [0:IDX_W-1]  idx_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Rotation is expressed on the numeric value, so the [0:31] MSB-first
  // declaration does not change its meaning.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/mod_msg_schedule_if.sv
// ---------------------------------------------------------------------------
// mod_msg_schedule_if
// Stream bundle around the message-schedule expander.
//   in_valid / in_ready / in_word : message words from the block loader
//   w_valid / w_ready / w_word    : schedule words to the round engine
//   w_idx                         : index t of w_word
//   w_last                        : marks the final schedule word of a block
// Modports:
//   master : the surrounding system (drives input words and w_ready)
//   slave  : the expander itself
// ---------------------------------------------------------------------------
interface mod_msg_schedule_if;
  import sha256_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_word;

  logic  w_valid;
  logic  w_ready;
  word_t w_word;
  idx_t  w_idx;
  logic  w_last;

  modport master (
    output in_valid,
    output in_word,
    output w_ready,
    input  in_ready,
    input  w_valid,
    input  w_word,
    input  w_idx,
    input  w_last
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  w_ready,
    output in_ready,
    output w_valid,
    output w_word,
    output w_idx,
    output w_last
  );

endinterface

// File: rtl/MOD_SIGMA0.sv
// ---------------------------------------------------------------------------
// MOD_SIGMA0
// SHA-256 small sigma 0: ROTR7(x) ^ ROTR18(x) ^ SHR3(x). Purely combinational.
//   x_i : input word
//   y_o : sigma0(x_i)
// ---------------------------------------------------------------------------
module MOD_SIGMA0
  import sha256_pkg::*;
(
  input  word_t x_i,
  output word_t y_o
);

  assign y_o = rotr(x_i, 7) ^ rotr(x_i, 18) ^ (x_i >> 3);

endmodule

// File: rtl/MOD_SIGMA1.sv
// ---------------------------------------------------------------------------
// MOD_SIGMA1
// SHA-256 small sigma 1: ROTR17(x) ^ ROTR19(x) ^ SHR10(x). Purely combinational.
//   x_i : input word
//   y_o : sigma1(x_i)
// ---------------------------------------------------------------------------
module MOD_SIGMA1
  import sha256_pkg::*;
(
  input  word_t x_i,
  output word_t y_o
);

  assign y_o = rotr(x_i, 17) ^ rotr(x_i, 19) ^ (x_i >> 10);

endmodule

// File: rtl/mod_msg_schedule.sv
// ---------------------------------------------------------------------------
// mod_msg_schedule
// SHA-256 message-schedule expander. Loads one block as 16 big-endian words,
// then streams W[0..ROUNDS-1] out in order using a 16-word sliding window.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   bus_io  : slave side of mod_msg_schedule_if
//             in_*  -> word input stream (accepted only while loading)
//             w_*   -> schedule word output stream, registered outputs
// Parameter:
//   ROUNDS  : schedule words per block (64 for SHA-256, 16..64 for tests)
// ---------------------------------------------------------------------------
module mod_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_MAX
) (
  input logic               clk_i,
  input logic               rst_i,
  mod_msg_schedule_if.slave bus_io
);

  localparam idx_t       LAST_IDX  = idx_t'(ROUNDS - 1);
  localparam logic [3:0] LOAD_LAST = 4'(BLOCK_WORDS - 1);

  // Slot 0 is the oldest word and is always the word presented downstream;
  // new words (loaded or expanded) enter at slot BLOCK_WORDS-1.
  word_t [BLOCK_WORDS-1:0] window_q;

  state_e     state_q;
  logic [3:0] load_cnt_q;
  idx_t       t_q;
  logic       in_ready_q;
  logic       w_valid_q;
  logic       w_last_q;

  word_t sigma0_w;
  word_t sigma1_w;
  word_t expand_d;
  logic  in_fire;
  logic  out_fire;

  // With W[t] in slot 0, slots 1, 9 and 14 hold W[t+1], W[t+9] and W[t+14],
  // which are exactly the terms needed for W[t+16].
  MOD_SIGMA0 u_sigma0 (
    .x_i (window_q[1]),
    .y_o (sigma0_w)
  );

  MOD_SIGMA1 u_sigma1 (
    .x_i (window_q[14]),
    .y_o (sigma1_w)
  );

  assign expand_d = sigma1_w + window_q[9] + sigma0_w + window_q[0];

  // The ready/valid flops are only ever set in their own state, so the
  // handshakes need no extra state qualification.
  assign in_fire  = bus_io.in_valid & in_ready_q;
  assign out_fire = w_valid_q & bus_io.w_ready;

  // Controller and window. Every output comes straight from a flop, so
  // w_ready never reaches an output combinationally and the outputs hold
  // whenever the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      t_q        <= '0;
      window_q   <= '0;
      in_ready_q <= 1'b1;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_fire) begin
            window_q <= {bus_io.in_word, window_q[BLOCK_WORDS-1:1]};
            if (load_cnt_q == LOAD_LAST) begin
              state_q    <= EMIT;
              load_cnt_q <= '0;
              t_q        <= '0;
              in_ready_q <= 1'b0;
              w_valid_q  <= 1'b1;
              w_last_q   <= (LAST_IDX == '0);
            end else begin
              load_cnt_q <= load_cnt_q + 4'd1;
            end
          end
        end

        EMIT: begin
          if (out_fire) begin
            window_q <= {expand_d, window_q[BLOCK_WORDS-1:1]};
            if (w_last_q) begin
              state_q    <= LOAD;
              load_cnt_q <= '0;
              t_q        <= '0;
              in_ready_q <= 1'b1;
              w_valid_q  <= 1'b0;
              w_last_q   <= 1'b0;
            end else begin
              t_q      <= t_q + idx_t'(1);
              w_last_q <= ((t_q + idx_t'(1)) == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign bus_io.in_ready = in_ready_q;
  assign bus_io.w_valid  = w_valid_q;
  assign bus_io.w_word   = window_q[0];
  assign bus_io.w_idx    = t_q;
  assign bus_io.w_last   = w_last_q;

endmodule

// File: tb/tb_mod_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_mod_msg_schedule
// Self-checking bench for mod_msg_schedule. Expected schedule words come from
// the textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
// evaluated over a flat array, plus published "abc" constants.
// ---------------------------------------------------------------------------
module tb_mod_msg_schedule;
  import sha256_pkg::*;

  localparam int NW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_msg_schedule_if bus ();

  mod_msg_schedule #(.ROUNDS(NW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  word_t      blkWords[16];
  word_t      expW[NW];
  word_t      gotW[NW];
  logic [5:0] gotIdx[NW];
  logic       gotLast[NW];

  int   stallErrors;
  int   inReadyInEmit;
  int   loadCycles;
  int   emitCycles;
  bit   timedOut;
  logic firstValid;
  logic postInReady;
  logic postValid;

  // Reference model helpers, written from the SHA-256 definitions.
  function automatic word_t rotr32(input word_t x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic void computeModel();
    for (int i = 0; i < 16; i++) expW[i] = blkWords[i];
    for (int t = 16; t < NW; t++)
      expW[t] = ssig1(expW[t-2]) + expW[t-7] + ssig0(expW[t-15]) + expW[t-16];
  endfunction

  function automatic void loadAbc();
    for (int i = 0; i < 16; i++) blkWords[i] = 32'h0;
    blkWords[0]  = 32'h61626380;
    blkWords[15] = 32'h00000018;
  endfunction

  function automatic void loadZero();
    for (int i = 0; i < 16; i++) blkWords[i] = 32'h0;
  endfunction

  function automatic void loadRandom();
    for (int i = 0; i < 16; i++) blkWords[i] = $urandom;
  endfunction

  // Drives one block in and collects the schedule words coming out.
  // stopLoad / stopEmit >= 0 return early (at a negedge) for the reset tests.
  task automatic applyStimulus(input bit gapIn, input bit holdValid, input int readyPct,
                               input int stopLoad, input int stopEmit);
    int         k;
    int         n;
    int         cyc;
    bit         prevStall;
    word_t      prevWord;
    logic [5:0] prevIdx;
    k = 0; n = 0; cyc = 0; prevStall = 0; prevWord = '0; prevIdx = '0;
    stallErrors = 0; inReadyInEmit = 0; loadCycles = 0; emitCycles = 0; timedOut = 0;
    firstValid = 1'bx; postInReady = 1'bx; postValid = 1'bx;
    bus.w_ready = 1'b0;
    while (k < 16 && !(stopLoad >= 0 && k == stopLoad)) begin
      @(negedge clk);
      if (gapIn && (cyc % 2 == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_word  = $urandom;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_word  = blkWords[k];
      end
      if (bus.in_valid && bus.in_ready) k++;
      loadCycles++;
      cyc++;
      if (cyc > 200) begin
        timedOut = 1;
        break;
      end
    end
    if (stopLoad >= 0 || timedOut) return;
    @(negedge clk);
    firstValid = bus.w_valid;
    while (n < NW) begin
      if (stopEmit >= 0 && n == stopEmit) return;
      if (prevStall && (bus.w_word !== prevWord || bus.w_idx !== prevIdx)) stallErrors++;
      if (bus.in_ready) inReadyInEmit++;
      bus.in_valid = holdValid;
      bus.in_word  = $urandom;
      bus.w_ready  = ($urandom_range(99) < readyPct);
      if (bus.w_valid && bus.w_ready) begin
        gotW[n]    = bus.w_word;
        gotIdx[n]  = bus.w_idx;
        gotLast[n] = bus.w_last;
        n++;
        prevStall = 0;
      end else begin
        prevStall = bus.w_valid;
      end
      prevWord = bus.w_word;
      prevIdx  = bus.w_idx;
      emitCycles++;
      if (emitCycles > 2000) begin
        timedOut = 1;
        break;
      end
      @(negedge clk);
    end
    postInReady  = bus.in_ready;
    postValid    = bus.w_valid;
    bus.w_ready  = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.w_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    testsRun++;
    if (bus.in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    testsRun++;
    if (bus.w_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_w_valid: got %b expected 0", bus.w_valid); end
    testsRun++;
    if (bus.w_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_w_last: got %b expected 0", bus.w_last); end
    testsRun++;
    if (bus.w_idx !== 6'd0) begin testsFailed++; $display("[TB] FAIL reset_w_idx: got %0d expected 0", bus.w_idx); end
    testsRun++;
    if (bus.w_word !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_w_word: got %h expected 0", bus.w_word); end
    @(negedge clk);
    testsRun++;
    if (bus.in_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: in_ready=%b w_valid=%b expected 1/0", bus.in_ready, bus.w_valid);
    end
  endtask

  task automatic test_abc();
    int    kIdx[5];
    word_t kVal[5];
    kIdx = '{16, 17, 18, 19, 63};
    kVal = '{32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6, 32'h12B1EDEB};
    loadAbc();
    computeModel();
    applyStimulus(1'b0, 1'b0, 100, -1, -1);
    testsRun++;
    if (timedOut) begin testsFailed++; $display("[TB] FAIL abc_timeout: got timeout expected completion"); end
    testsRun++;
    if (firstValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL abc_first_valid_latency: got %b expected 1", firstValid); end
    testsRun++;
    if (loadCycles + emitCycles != 16 + NW) begin
      testsFailed++;
      $display("[TB] FAIL abc_block_cycles: got %0d expected %0d", loadCycles + emitCycles, 16 + NW);
    end
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (gotW[kIdx[i]] !== kVal[i]) begin
        testsFailed++;
        $display("[TB] FAIL abc_known_W%0d: got %h expected %h", kIdx[i], gotW[kIdx[i]], kVal[i]);
      end
    end
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== expW[n] || gotIdx[n] !== 6'(n) || gotLast[n] !== (n == NW - 1)) begin
        testsFailed++;
        $display("[TB] FAIL abc_word[%0d]: got %h idx %0d last %b expected %h idx %0d last %b",
                 n, gotW[n], gotIdx[n], gotLast[n], expW[n], n, (n == NW - 1));
      end
    end
    testsRun++;
    if (postInReady !== 1'b1 || postValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abc_return_to_load: in_ready=%b w_valid=%b expected 1/0", postInReady, postValid);
    end
  endtask

  task automatic test_zero();
    loadZero();
    applyStimulus(1'b0, 1'b0, 100, -1, -1);
    testsRun++;
    if (timedOut) begin testsFailed++; $display("[TB] FAIL zero_timeout: got timeout expected 64 handshakes"); end
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== 32'h0 || gotIdx[n] !== 6'(n)) begin
        testsFailed++;
        $display("[TB] FAIL zero_word[%0d]: got %h idx %0d expected 00000000 idx %0d", n, gotW[n], gotIdx[n], n);
      end
    end
    testsRun++;
    if (postInReady !== 1'b1 || postValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_after_64: in_ready=%b w_valid=%b expected 1/0", postInReady, postValid);
    end
  endtask

  task automatic test_backpressure();
    loadAbc();
    computeModel();
    applyStimulus(1'b0, 1'b0, 45, -1, -1);
    testsRun++;
    if (timedOut) begin testsFailed++; $display("[TB] FAIL bp_timeout: got timeout expected completion"); end
    testsRun++;
    if (stallErrors != 0) begin testsFailed++; $display("[TB] FAIL bp_stall_stability: got %0d changes expected 0", stallErrors); end
    testsRun++;
    if (inReadyInEmit != 0) begin testsFailed++; $display("[TB] FAIL bp_in_ready_low: got %0d cycles high expected 0", inReadyInEmit); end
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== expW[n] || gotIdx[n] !== 6'(n)) begin
        testsFailed++;
        $display("[TB] FAIL bp_word[%0d]: got %h idx %0d expected %h idx %0d", n, gotW[n], gotIdx[n], expW[n], n);
      end
    end
  endtask

  task automatic test_gappy_input();
    loadAbc();
    computeModel();
    applyStimulus(1'b1, 1'b1, 100, -1, -1);
    testsRun++;
    if (timedOut) begin testsFailed++; $display("[TB] FAIL gap_timeout: got timeout expected completion"); end
    testsRun++;
    if (loadCycles != 31) begin testsFailed++; $display("[TB] FAIL gap_load_cycles: got %0d expected 31", loadCycles); end
    testsRun++;
    if (inReadyInEmit != 0) begin testsFailed++; $display("[TB] FAIL gap_in_ready_low: got %0d cycles high expected 0", inReadyInEmit); end
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== expW[n]) begin
        testsFailed++;
        $display("[TB] FAIL gap_word[%0d]: got %h expected %h", n, gotW[n], expW[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    loadAbc();
    computeModel();
    // Reset after 7 words, while an 8th word is being offered.
    applyStimulus(1'b0, 1'b0, 100, 7, -1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_word  = blkWords[7];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    testsRun++;
    if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_load7: w_valid=%b in_ready=%b expected 0/1", bus.w_valid, bus.in_ready);
    end
    applyStimulus(1'b0, 1'b0, 100, -1, -1);
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== expW[n]) begin
        testsFailed++;
        $display("[TB] FAIL rst_load7_reload[%0d]: got %h expected %h", n, gotW[n], expW[n]);
      end
    end
    // Reset while W[20] is on offer and being accepted.
    applyStimulus(1'b0, 1'b0, 100, -1, 20);
    testsRun++;
    if (bus.w_idx !== 6'd20 || bus.w_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_emit20_reached: idx %0d valid %b expected 20/1", bus.w_idx, bus.w_valid);
    end
    bus.w_ready  = 1'b1;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.w_ready  = 1'b0;
    bus.in_valid = 1'b0;
    testsRun++;
    if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.w_word !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rst_emit20: w_valid=%b in_ready=%b w_word=%h expected 0/1/00000000",
               bus.w_valid, bus.in_ready, bus.w_word);
    end
    applyStimulus(1'b0, 1'b0, 100, -1, -1);
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== expW[n] || gotIdx[n] !== 6'(n)) begin
        testsFailed++;
        $display("[TB] FAIL rst_emit20_reload[%0d]: got %h idx %0d expected %h idx %0d", n, gotW[n], gotIdx[n], expW[n], n);
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t firstW[NW];
    loadAbc();
    computeModel();
    applyStimulus(1'b0, 1'b1, 100, -1, -1);
    for (int n = 0; n < NW; n++) firstW[n] = gotW[n];
    testsRun++;
    if (inReadyInEmit != 0 || postInReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_in_ready: high %0d cycles, after last %b expected 0/1", inReadyInEmit, postInReady);
    end
    applyStimulus(1'b0, 1'b1, 80, -1, -1);
    testsRun++;
    if (inReadyInEmit != 0 || postInReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_in_ready: high %0d cycles, after last %b expected 0/1", inReadyInEmit, postInReady);
    end
    for (int n = 0; n < NW; n++) begin
      testsRun++;
      if (gotW[n] !== firstW[n] || gotW[n] !== expW[n]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_word[%0d]: second %h first %h expected %h", n, gotW[n], firstW[n], expW[n]);
      end
    end
  endtask

  task automatic test_random_blocks();
    for (int b = 0; b < 3; b++) begin
      loadRandom();
      computeModel();
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 70, -1, -1);
      testsRun++;
      if (timedOut || stallErrors != 0) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_flow: timeout %0d stall changes %0d expected 0/0", b, timedOut, stallErrors);
      end
      for (int n = 0; n < NW; n++) begin
        testsRun++;
        if (gotW[n] !== expW[n] || gotLast[n] !== (n == NW - 1)) begin
          testsFailed++;
          $display("[TB] FAIL rand%0d_word[%0d]: got %h last %b expected %h last %b",
                   b, n, gotW[n], gotLast[n], expW[n], (n == NW - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_gappy_input();
    test_reset_mid();
    test_back_to_back();
    test_random_blocks();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
